// File: rtl/ex_stage_muldiv_if.sv
// Execute-stage bus: ID/EX operands and controls in, EX/MEM register and stall out.
interface ex_stage_muldiv_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    logic               in_valid;
    logic [3:0]         in_alu_op;
    logic [DATA_W-1:0]  in_rs_data;
    logic [DATA_W-1:0]  in_rt_data;
    logic [DATA_W-1:0]  in_imm;
    logic               in_alu_src;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_mem_read;
    logic               in_mem_write;
    logic               in_reg_write;
    logic               in_mem_to_reg;
    logic               in_branch;
    logic [1:0]         in_load_mode;
    logic [4:0]         in_write_reg;

    logic               stall_out;
    logic               out_valid;
    logic [DATA_W-1:0]  out_address;
    logic [DATA_W-1:0]  out_write_data;
    logic               out_mem_read;
    logic               out_mem_write;
    logic               out_reg_write;
    logic               out_mem_to_reg;
    logic               out_branch;
    logic [1:0]         out_load_mode;
    logic               out_zero;
    logic [4:0]         out_write_reg;

    modport master (
        output in_valid, in_alu_op, in_rs_data, in_rt_data, in_imm, in_alu_src, in_shamt,
               in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_branch,
               in_load_mode, in_write_reg,
        input  stall_out, out_valid, out_address, out_write_data, out_mem_read, out_mem_write,
               out_reg_write, out_mem_to_reg, out_branch, out_load_mode, out_zero, out_write_reg
    );

    modport slave (
        input  in_valid, in_alu_op, in_rs_data, in_rt_data, in_imm, in_alu_src, in_shamt,
               in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_branch,
               in_load_mode, in_write_reg,
        output stall_out, out_valid, out_address, out_write_data, out_mem_read, out_mem_write,
               out_reg_write, out_mem_to_reg, out_branch, out_load_mode, out_zero, out_write_reg
    );
endinterface

// File: rtl/ex_stage_muldiv.sv
// Execute stage: ALU, EX/MEM pipeline register and an optional iterative mul/div unit with HI/LO.
// Define EX_MULDIV_EN to build the mul/div engine; otherwise ops 9-14 yield 0 and stall_out is 0.
module ex_stage_muldiv #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_stage_muldiv_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR    = 4'd3,
        OP_NOR  = 4'd4,  OP_SLT  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL   = 4'd7,
        OP_SRA  = 4'd8,  OP_MFHI = 4'd9,  OP_MFLO = 4'd10, OP_MULT  = 4'd11,
        OP_MULTU= 4'd12, OP_DIV  = 4'd13, OP_DIVU = 4'd14, OP_RSV   = 4'd15
    } alu_op_e;

    if (MD_CYCLES != DATA_W) begin : g_bad_cfg
        $error("MD_CYCLES must equal DATA_W");
    end

    logic [DATA_W-1:0] opnd_b_c;
    logic [DATA_W-1:0] alu_result_c;

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_e;
    localparam int unsigned CNT_W = $clog2(MD_CYCLES);

    md_state_e           md_state;
    logic [CNT_W-1:0]    md_cnt;
    logic                md_div, md_neg_q, md_neg_r, md_div_zero;
    logic [DATA_W-1:0]   acc_hi, acc_lo, md_opnd;
    logic [DATA_W-1:0]   hi, lo;

    logic                md_start_c, op_signed_c, a_neg_c, b_neg_c;
    logic [DATA_W-1:0]   a_abs_c, b_abs_c, q_fix_c, r_fix_c;
    logic [DATA_W:0]     mul_sum_c, div_shift_c, div_diff_c;
    logic [2*DATA_W-1:0] prod_fix_c;
`endif

    // ALU; mul/div ops themselves produce 0 on the address path
    always_comb begin
        opnd_b_c     = bus.in_alu_src ? bus.in_imm : bus.in_rt_data;
        alu_result_c = '0;
        case (bus.in_alu_op)
            OP_ADD:  alu_result_c = bus.in_rs_data + opnd_b_c;
            OP_SUB:  alu_result_c = bus.in_rs_data - opnd_b_c;
            OP_AND:  alu_result_c = bus.in_rs_data & opnd_b_c;
            OP_OR:   alu_result_c = bus.in_rs_data | opnd_b_c;
            OP_NOR:  alu_result_c = ~(bus.in_rs_data | opnd_b_c);
            OP_SLT:  alu_result_c = DATA_W'($signed(bus.in_rs_data) < $signed(opnd_b_c));
            OP_SLL:  alu_result_c = opnd_b_c << bus.in_shamt;
            OP_SRL:  alu_result_c = opnd_b_c >> bus.in_shamt;
            OP_SRA:  alu_result_c = DATA_W'($signed(opnd_b_c) >>> bus.in_shamt);
`ifdef EX_MULDIV_EN
            OP_MFHI: alu_result_c = hi;
            OP_MFLO: alu_result_c = lo;
`endif
            default: alu_result_c = '0;
        endcase
    end

    // EX/MEM register; stall or invalid slot inserts a bubble and data fields hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid      <= 1'b0;
            bus.out_address    <= '0;
            bus.out_write_data <= '0;
            bus.out_mem_read   <= 1'b0;
            bus.out_mem_write  <= 1'b0;
            bus.out_reg_write  <= 1'b0;
            bus.out_mem_to_reg <= 1'b0;
            bus.out_branch     <= 1'b0;
            bus.out_load_mode  <= 2'd0;
            bus.out_zero       <= 1'b0;
            bus.out_write_reg  <= 5'd0;
        end else if (bus.stall_out || !bus.in_valid) begin
            bus.out_valid      <= 1'b0;
            bus.out_mem_read   <= 1'b0;
            bus.out_mem_write  <= 1'b0;
            bus.out_reg_write  <= 1'b0;
            bus.out_branch     <= 1'b0;
        end else begin
            bus.out_valid      <= 1'b1;
            bus.out_address    <= alu_result_c;
            bus.out_write_data <= bus.in_rt_data;
            bus.out_mem_read   <= bus.in_mem_read;
            bus.out_mem_write  <= bus.in_mem_write;
            bus.out_reg_write  <= bus.in_reg_write;
            bus.out_mem_to_reg <= bus.in_mem_to_reg;
            bus.out_branch     <= bus.in_branch;
            bus.out_load_mode  <= bus.in_load_mode;
            bus.out_zero       <= (alu_result_c == '0);
            bus.out_write_reg  <= bus.in_write_reg;
        end
    end

`ifdef EX_MULDIV_EN
    // Engine runs on magnitudes; signs are reapplied in FIX
    always_comb begin
        md_start_c  = bus.in_valid && !bus.stall_out &&
                      (bus.in_alu_op >= OP_MULT) && (bus.in_alu_op <= OP_DIVU);
        op_signed_c = (bus.in_alu_op == OP_MULT) || (bus.in_alu_op == OP_DIV);
        a_neg_c     = op_signed_c && bus.in_rs_data[DATA_W-1];
        b_neg_c     = op_signed_c && bus.in_rt_data[DATA_W-1];
        a_abs_c     = a_neg_c ? -bus.in_rs_data : bus.in_rs_data;
        b_abs_c     = b_neg_c ? -bus.in_rt_data : bus.in_rt_data;
        mul_sum_c   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, md_opnd}) : {1'b0, acc_hi};
        div_shift_c = {acc_hi, acc_lo[DATA_W-1]};
        div_diff_c  = div_shift_c - {1'b0, md_opnd};
        prod_fix_c  = md_neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        q_fix_c     = md_neg_q ? -acc_lo : acc_lo;
        r_fix_c     = md_neg_r ? -acc_hi : acc_hi;
    end

    // Mul/div FSM: shift-add multiply, restoring divide (acc_hi=remainder, acc_lo=quotient)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state      <= MD_IDLE;
            md_cnt        <= '0;
            md_div        <= 1'b0;
            md_neg_q      <= 1'b0;
            md_neg_r      <= 1'b0;
            md_div_zero   <= 1'b0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            md_opnd       <= '0;
            hi            <= '0;
            lo            <= '0;
            bus.stall_out <= 1'b0;
        end else begin
            case (md_state)
                MD_IDLE: if (md_start_c) begin
                    md_state      <= MD_RUN;
                    md_cnt        <= '0;
                    md_div        <= (bus.in_alu_op == OP_DIV) || (bus.in_alu_op == OP_DIVU);
                    md_neg_q      <= a_neg_c ^ b_neg_c;
                    md_neg_r      <= a_neg_c;
                    md_div_zero   <= (bus.in_rt_data == '0);
                    acc_hi        <= '0;
                    acc_lo        <= a_abs_c;
                    md_opnd       <= b_abs_c;
                    bus.stall_out <= 1'b1;
                end
                MD_RUN: begin
                    if (!md_div) begin
                        acc_hi <= mul_sum_c[DATA_W:1];
                        acc_lo <= {mul_sum_c[0], acc_lo[DATA_W-1:1]};
                    end else if (!div_diff_c[DATA_W]) begin
                        acc_hi <= div_diff_c[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift_c[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
                    end
                    md_cnt <= md_cnt + 1'b1;
                    if (md_cnt == CNT_W'(MD_CYCLES - 1)) md_state <= MD_FIX;
                end
                MD_FIX: begin
                    if (!md_div) begin
                        {hi, lo} <= prod_fix_c;
                    end else begin
                        hi <= r_fix_c;
                        lo <= md_div_zero ? '1 : q_fix_c;
                    end
                    md_state      <= MD_IDLE;
                    bus.stall_out <= 1'b0;
                end
                default: md_state <= MD_IDLE;
            endcase
        end
    end
`else
    assign bus.stall_out = 1'b0;
`endif

endmodule
